// File: rtl/axil_slave_regfile.sv
// ---------------------------------------------------------------------------
// axil_slave_regfile
// AXI4-Lite slave exposing DEPTH registers of DATA_WIDTH bits.
//  - Write path: AW and W are captured independently into holding registers;
//    the write commits one cycle after both are held, then B is returned.
//  - Read path: three-process FSM (IDLE / WAIT / RESP) with RD_LATENCY extra
//    idle cycles between the AR handshake and rvalid.
//  - Optional feature macro AXIL_SLAVE_REGFILE_STATS_EN: when defined,
//    wr_count / rd_count count completed B / R handshakes; otherwise both
//    ports are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module axil_slave_regfile #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 0
) (
   input  logic                      aclk,
   input  logic                      reset,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
   input  logic                      s_axil_awvalid,
   output logic                      s_axil_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
   input  logic                      s_axil_wvalid,
   output logic                      s_axil_wready,
   // write response channel
   output logic [1:0]                s_axil_bresp,
   output logic                      s_axil_bvalid,
   input  logic                      s_axil_bready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
   input  logic                      s_axil_arvalid,
   output logic                      s_axil_arready,
   // read data channel
   output logic [DATA_WIDTH-1:0]     s_axil_rdata,
   output logic [1:0]                s_axil_rresp,
   output logic                      s_axil_rvalid,
   input  logic                      s_axil_rready,
   // statistics
   output logic [31:0]               wr_count,
   output logic [31:0]               rd_count
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Last WAIT count value before moving to RESP (unused when RD_LATENCY == 0).
   localparam logic [3:0] LAT_LAST = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } rd_state_e;

   // ------------------------------------------------------------------------
   // Address decode: word index above the byte-lane bits; anything that does
   // not fit in IDX_W bits is out of range.
   // ------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] aw_word, ar_word;
   logic [IDX_W-1:0]      aw_idx,  ar_idx;
   logic                  aw_oor,  ar_oor;

   assign aw_word = s_axil_awaddr >> LSB;
   assign ar_word = s_axil_araddr >> LSB;
   assign aw_idx  = aw_word[IDX_W-1:0];
   assign ar_idx  = ar_word[IDX_W-1:0];
   assign aw_oor  = |(aw_word >> IDX_W);
   assign ar_oor  = |(ar_word >> IDX_W);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                    live_q, live_d;       // low only in the cycle after a reset edge
   logic                    aw_held_q, aw_held_d;
   logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
   logic                    aw_oor_q, aw_oor_d;
   logic                    w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
   logic [STRB_W-1:0]       w_strb_q, w_strb_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;

   logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   wr_word;

   rd_state_e               state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic aw_hs, w_hs, b_hs, ar_hs;

   assign aw_hs = s_axil_awvalid & s_axil_awready;
   assign w_hs  = s_axil_wvalid  & s_axil_wready;
   assign b_hs  = bvalid_q       & s_axil_bready;
   assign ar_hs = s_axil_arvalid & s_axil_arready;

   // Write channel next state: capture AW/W, raise B once both are held,
   // release everything on the B handshake.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can
      // leave it unassigned, which would otherwise infer a latch.
      live_d    = 1'b1;
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      aw_oor_d  = aw_oor_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = aw_idx;
         aw_oor_d  = aw_oor;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = s_axil_wdata;
         w_strb_d = s_axil_wstrb;
      end
      // Commit cycle: both halves held and no response outstanding yet.
      if (aw_held_q && w_held_q && !bvalid_q) begin
         bvalid_d = 1'b1;
         bresp_d  = aw_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_hs) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b0;
         bresp_d   = RESP_OKAY;
      end
   end

   // Byte-merge of the held write data into the addressed register.
   always_comb begin
      wr_en   = aw_held_q & w_held_q & ~bvalid_q & ~aw_oor_q;
      wr_word = regs_q[aw_idx_q];
      for (int b = 0; b < STRB_W; b++) begin
         if (w_strb_q[b]) wr_word[8*b +: 8] = w_data_q[8*b +: 8];
      end
   end

   // Write channel registers.
   always_ff @(posedge aclk) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge values of the others, independent of statement order.
      if (reset) begin
         live_q    <= 1'b0;
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         aw_oor_q  <= 1'b0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         live_q    <= live_d;
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         aw_oor_q  <= aw_oor_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Register array; reset wins over a coinciding commit.
   always_ff @(posedge aclk) begin
      // NOTE: the array is reset explicitly because software expects every
      // register to read zero after reset; this keeps it out of RAM macros.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[aw_idx_q] <= wr_word;
      end
   end

   // Read FSM: state register.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

   // Read FSM: next state; data is captured at the AR handshake, so a write
   // committing on the same edge is not visible to this read.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      case (state_q)
         S_IDLE: begin
            if (ar_hs) begin
               state_d = (RD_LATENCY > 0) ? S_WAIT : S_RESP;
               cnt_d   = '0;
               rdata_d = ar_oor ? '0 : regs_q[ar_idx];
               rresp_d = ar_oor ? RESP_SLVERR : RESP_OKAY;
            end
         end
         S_WAIT: begin
            if (cnt_q == LAT_LAST) state_d = S_RESP;
            else                   cnt_d   = cnt_q + 4'd1;
         end
         S_RESP: begin
            if (s_axil_rready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: readies are held low in the cycle following a reset edge.
   always_comb begin
      s_axil_awready = live_q & ~aw_held_q & ~bvalid_q;
      s_axil_wready  = live_q & ~w_held_q  & ~bvalid_q;
      s_axil_arready = live_q & (state_q == S_IDLE);
      s_axil_rvalid  = (state_q == S_RESP);
   end

   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rdata  = rdata_q;
   assign s_axil_rresp  = rresp_q;

`ifdef AXIL_SLAVE_REGFILE_STATS_EN
   logic        r_hs;
   logic [31:0] wr_count_q, wr_count_d;
   logic [31:0] rd_count_q, rd_count_d;

   assign r_hs = s_axil_rvalid & s_axil_rready;

   // Handshake counters, wrapping naturally at 2^32.
   always_comb begin
      wr_count_d = wr_count_q + 32'(b_hs);
      rd_count_d = rd_count_q + 32'(r_hs);
   end

   // Counter registers.
   always_ff @(posedge aclk) begin
      if (reset) begin
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;
`else
   assign wr_count = '0;
   assign rd_count = '0;
`endif

endmodule

// File: tb/tb_axil_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_axil_slave_regfile
// Randomized and directed AXI4-Lite traffic against an array-based model of
// the register file (32-bit data, 16 registers, RD_LATENCY = 3).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axil_slave_regfile;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;

   logic          aclk;
   logic          reset;
   logic [AW-1:0] s_axil_awaddr;
   logic          s_axil_awvalid;
   logic          s_axil_awready;
   logic [DW-1:0] s_axil_wdata;
   logic [3:0]    s_axil_wstrb;
   logic          s_axil_wvalid;
   logic          s_axil_wready;
   logic [1:0]    s_axil_bresp;
   logic          s_axil_bvalid;
   logic          s_axil_bready;
   logic [AW-1:0] s_axil_araddr;
   logic          s_axil_arvalid;
   logic          s_axil_arready;
   logic [DW-1:0] s_axil_rdata;
   logic [1:0]    s_axil_rresp;
   logic          s_axil_rvalid;
   logic          s_axil_rready;
   logic [31:0]   wr_count;
   logic [31:0]   rd_count;

   axil_slave_regfile #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .RD_LATENCY (LAT)
   ) dut (
      .aclk           (aclk),
      .reset          (reset),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .wr_count       (wr_count),
      .rd_count       (rd_count)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Reference model and bookkeeping.
   logic [31:0] mem [DEPTH];
   int checks = 0;
   int errors = 0;
   int n_wr = 0;        // completed B handshakes since last reset
   int n_rd = 0;        // completed R handshakes since last reset
   int exp_rises = 0;   // bvalid assertions the bench expects
   int b_rises = 0;
   bit b_prev = 1'b0;

   always @(negedge aclk) begin
      if (s_axil_bvalid === 1'b1 && !b_prev) b_rises <= b_rises + 1;
      b_prev <= (s_axil_bvalid === 1'b1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_wr_count();
`ifdef AXIL_SLAVE_REGFILE_STATS_EN
      return n_wr;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_rd_count();
`ifdef AXIL_SLAVE_REGFILE_STATS_EN
      return n_rd;
`else
      return 0;
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      n_wr = 0;
      n_rd = 0;
   endtask

   // Full write transaction; AW and W start at independent cycle offsets.
   task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_start, input int w_start,
                             input int b_delay, input bit do_ack);
      int idx = int'(addr[AW-1:2]);
      bit oor = (idx >= DEPTH);
      logic [1:0] exp_resp = oor ? 2'b10 : 2'b00;
      bit aw_done = 1'b0;
      bit w_done = 1'b0;
      bit aw_fire, w_fire;
      int c = 0;
      s_axil_awaddr = addr;
      s_axil_wdata  = data;
      s_axil_wstrb  = strb;
      while (!(aw_done && w_done) && c < 200) begin
         if (c == aw_start) s_axil_awvalid = 1'b1;
         if (c == w_start)  s_axil_wvalid  = 1'b1;
         aw_fire = s_axil_awvalid && s_axil_awready;
         w_fire  = s_axil_wvalid  && s_axil_wready;
         @(negedge aclk);
         if (aw_fire) begin s_axil_awvalid = 1'b0; aw_done = 1'b1; end
         if (w_fire)  begin s_axil_wvalid  = 1'b0; w_done  = 1'b1; end
         c++;
      end
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      check("wr_accept", {aw_done, w_done}, 2'b11);
      exp_rises++;
      c = 0;
      while (!s_axil_bvalid && c < 20) begin @(negedge aclk); c++; end
      check("wr_bvalid", s_axil_bvalid, 1'b1);
      check("wr_bresp", s_axil_bresp, exp_resp);
      if (!oor) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
      end
      for (int i = 0; i < b_delay; i++) begin
         @(negedge aclk);
         check("wr_bhold", {s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready},
               {1'b1, exp_resp, 2'b00});
      end
      if (do_ack) begin
         s_axil_bready = 1'b1;
         @(negedge aclk);
         s_axil_bready = 1'b0;
         n_wr++;
         check("wr_bdone", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
      end
   endtask

   // Full read transaction with latency and hold checks.
   task automatic axil_read(input logic [AW-1:0] addr, input int r_delay, input bit do_ack);
      int idx = int'(addr[AW-1:2]);
      bit oor = (idx >= DEPTH);
      logic [31:0] exp_data = oor ? 32'h0 : mem[idx];
      logic [1:0]  exp_resp = oor ? 2'b10 : 2'b00;
      int c = 0;
      s_axil_araddr  = addr;
      s_axil_arvalid = 1'b1;
      while (!s_axil_arready && c < 50) begin @(negedge aclk); c++; end
      check("rd_arready", s_axil_arready, 1'b1);
      @(negedge aclk);
      s_axil_arvalid = 1'b0;
      c = 1;
      while (!s_axil_rvalid && c < 50) begin
         check("rd_wait_arready", s_axil_arready, 1'b0);
         @(negedge aclk);
         c++;
      end
      check("rd_latency", c, LAT + 1);
      check("rd_data", s_axil_rdata, exp_data);
      check("rd_resp", s_axil_rresp, exp_resp);
      for (int i = 0; i < r_delay; i++) begin
         @(negedge aclk);
         check("rd_hold", {s_axil_rvalid, s_axil_arready, s_axil_rresp, s_axil_rdata},
               {1'b1, 1'b0, exp_resp, exp_data});
      end
      if (do_ack) begin
         s_axil_rready = 1'b1;
         @(negedge aclk);
         s_axil_rready = 1'b0;
         n_rd++;
         check("rd_done", s_axil_rvalid, 1'b0);
      end
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) axil_read(AW'(i * 4), 0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int rises0;
      logic [31:0] old;
      reset          = 1'b1;
      s_axil_awaddr  = '0;
      s_axil_awvalid = 1'b0;
      s_axil_wdata   = '0;
      s_axil_wstrb   = '0;
      s_axil_wvalid  = 1'b0;
      s_axil_bready  = 1'b0;
      s_axil_araddr  = '0;
      s_axil_arvalid = 1'b0;
      s_axil_rready  = 1'b0;
      clear_model();

      // Reset state.
      repeat (3) @(negedge aclk);
      check("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
      check("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
      check("rst_resp_data", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 36'h0);
      check("rst_counts", {wr_count, rd_count}, 64'h0);
      reset = 1'b0;
      @(negedge aclk);
      check("post_rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
      read_all();

      // Basic write then read.
      axil_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b1);
      axil_read(12'h004, 0, 1'b1);

      // W three cycles ahead of AW, partial strobes over all-ones.
      axil_write(12'h008, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 1'b1);
      rises0 = b_rises;
      axil_write(12'h008, 32'h11223344, 4'h5, 3, 0, 2, 1'b1);
      repeat (3) @(negedge aclk);
      check("single_commit", b_rises - rises0, 1);
      axil_read(12'h00A, 1, 1'b1);

      // Out-of-range read and write.
      axil_read(12'h040, 0, 1'b1);
      axil_write(12'h040, 32'h55AA55AA, 4'hF, 1, 0, 0, 1'b1);
      axil_read(12'hFFC, 0, 1'b1);
      read_all();

      // Long rready stall.
      axil_read(12'h004, 5, 1'b1);

      // Write commit and AR handshake on the same edge to the same register.
      axil_write(12'h00C, 32'hAAAA5555, 4'hF, 0, 0, 0, 1'b1);
      old = mem[3];
      s_axil_awaddr  = 12'h00C;
      s_axil_wdata   = 32'h0F0F1234;
      s_axil_wstrb   = 4'hF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      @(negedge aclk);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      s_axil_araddr  = 12'h00C;
      s_axil_arvalid = 1'b1;
      check("same_arready", s_axil_arready, 1'b1);
      @(negedge aclk);
      s_axil_arvalid = 1'b0;
      check("same_bvalid", s_axil_bvalid, 1'b1);
      exp_rises++;
      repeat (LAT) @(negedge aclk);
      check("same_rvalid", s_axil_rvalid, 1'b1);
      check("same_old_data", s_axil_rdata, old);
      s_axil_rready = 1'b1;
      s_axil_bready = 1'b1;
      @(negedge aclk);
      s_axil_rready = 1'b0;
      s_axil_bready = 1'b0;
      n_rd++;
      n_wr++;
      mem[3] = 32'h0F0F1234;
      axil_read(12'h00C, 0, 1'b1);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 79));
         if ($urandom_range(0, 1) == 1)
            axil_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'b1);
         else
            axil_read(a, $urandom_range(0, 3), 1'b1);
      end
      read_all();
      check("wr_count", wr_count, exp_wr_count());
      check("rd_count", rd_count, exp_rd_count());

      // Reset with both a B and an R response pending.
      axil_write(12'h014, 32'hCAFEF00D, 4'hF, 0, 0, 0, 1'b0);
      axil_read(12'h014, 0, 1'b0);
      reset = 1'b1;
      @(negedge aclk);
      check("rst_pending", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
      check("rst_mid_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
      check("rst_mid_counts", {wr_count, rd_count}, 64'h0);
      reset = 1'b0;
      clear_model();
      @(negedge aclk);
      check("rst_mid_post_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
      read_all();

      // Reset coinciding with the commit cycle suppresses the write.
      s_axil_awaddr  = 12'h010;
      s_axil_wdata   = 32'h12345678;
      s_axil_wstrb   = 4'hF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      @(negedge aclk);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      reset = 1'b1;
      @(negedge aclk);
      reset = 1'b0;
      clear_model();
      @(negedge aclk);
      check("rst_commit_bvalid", s_axil_bvalid, 1'b0);
      axil_read(12'h010, 0, 1'b1);

      // Three writes and two reads for the statistics counters.
      axil_write(12'h000, 32'h00000001, 4'hF, 0, 1, 0, 1'b1);
      axil_write(12'h01C, 32'h00000002, 4'h3, 2, 0, 0, 1'b1);
      axil_write(12'h03C, 32'h00000003, 4'hC, 0, 0, 1, 1'b1);
      axil_read(12'h01C, 0, 1'b1);
      check("stats_wr", wr_count, exp_wr_count());
      check("stats_rd", rd_count, exp_rd_count());
      axil_read(12'h03C, 0, 1'b1);
      check("stats_rd2", rd_count, exp_rd_count());
      repeat (2) @(negedge aclk);
      check("b_rises", b_rises, exp_rises);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_slave_regfile.md
AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, 12, byte-address width of AW/AR channels.
REQ-002 Parameter DATA_WIDTH, 32, data width; legal values 32 or 64.
REQ-003 Parameter DEPTH, 16, number of DATA_WIDTH-bit registers; power of two, 2..1024.
REQ-004 Parameter RD_LATENCY, 0, extra idle cycles inserted between AR handshake and rvalid; range 0..15.
REQ-005 aclk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_axil_awaddr  input  ADDR_WIDTH  write address.
REQ-008 s_axil_awvalid / s_axil_awready  input / output  1  AW handshake.
REQ-009 s_axil_wdata  input  DATA_WIDTH  write data.
REQ-010 s_axil_wstrb  input  DATA_WIDTH/8  byte enables.
REQ-011 s_axil_wvalid / s_axil_wready  input / output  1  W handshake.
REQ-012 s_axil_bresp  output  2  write response, OKAY=00, SLVERR=10.
REQ-013 s_axil_bvalid / s_axil_bready  output / input  1  B handshake.
REQ-014 s_axil_araddr  input  ADDR_WIDTH  read address.
REQ-015 s_axil_arvalid / s_axil_arready  input / output  1  AR handshake.
REQ-016 s_axil_rdata  output  DATA_WIDTH  read data.
REQ-017 s_axil_rresp  output  2  read response, OKAY=00, SLVERR=10.
REQ-018 s_axil_rvalid / s_axil_rready  output / input  1  R handshake.
REQ-019 wr_count / rd_count  output  32 each  completed B / R handshake counters.

Function
REQ-020 Word index = addr bits [ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low bits ignored; index >= DEPTH is out of range.
REQ-021 awready high while no AW held and no B pending; wready high while no W held and no B pending; AW and W accepted independently, either order or same cycle.
REQ-022 In the cycle after both AW and W are held: write commits (only bytes with wstrb=1; none if out of range), bvalid asserts, bresp = OKAY or SLVERR (out of range).
REQ-023 bvalid/bresp held stable until bready; AW/W holding registers clear on B handshake; awready/wready reassert the following cycle.
REQ-024 Read FSM states IDLE, WAIT, RESP; arready = 1 only in IDLE.
REQ-025 IDLE + AR handshake: capture data and response at that edge, go to WAIT if RD_LATENCY>0 else RESP; WAIT counts RD_LATENCY cycles then RESP.
REQ-026 rvalid asserted exactly RD_LATENCY+1 cycles after AR handshake; rdata/rresp stable until rready; RESP + rready -> IDLE.
REQ-027 Out-of-range read: rresp = SLVERR, rdata = 0.
REQ-028 Same-cycle write commit and AR handshake to same index: read returns pre-write data.
REQ-029 Read and write channels operate fully concurrently; no ordering between them.
REQ-030 Counters wrap 0xFFFFFFFF -> 0; each increments on its handshake cycle, both may increment same cycle.

Reset
REQ-031 On reset: awready, wready, arready = 0 during reset cycle then 1; bvalid, rvalid = 0; bresp, rresp, rdata = 0; FSM = IDLE; all registers = 0; counters = 0.
REQ-032 Reset mid-transaction discards held AW/W, pending B and in-flight reads; no commit occurs for a write whose commit cycle coincides with reset.

Configuration
REQ-033 Macro AXIL_SLAVE_REGFILE_STATS_EN defined: wr_count/rd_count implemented per REQ-030.
REQ-034 Macro undefined: wr_count/rd_count ports remain, tied to 0, no counter flops.

Verification
REQ-035 (32-bit, DEPTH=16) W 0xDEADBEEF to 0x004 wstrb=0xF, then AR 0x004 -> bresp=00, rdata=0xDEADBEEF, rresp=00.
REQ-036 W data presented 3 cycles before AW at 0x008 -> single commit, one bvalid; write 0x11223344 wstrb=0x5 over 0xFFFFFFFF -> read 0xFF22FF44.
REQ-037 AR 0x040 (index 16) -> rresp=10, rdata=0; W 0x040 -> bresp=10, regs unchanged.
REQ-038 RD_LATENCY=3, AR at cycle N -> rvalid at N+4; rready low 5 cycles -> rdata stable, arready low throughout.
REQ-039 Reset asserted with bvalid and rvalid pending -> both 0 next cycle, all regs read 0 afterwards, counters 0.
REQ-040 STATS_EN: 3 writes + 2 reads -> wr_count=3, rd_count=2; without macro both 0.
